// File: rtl/jt12_timer_ctrl.sv
// jt12_timer_ctrl: CPU-side register front end for timers A/B (part I regs 0x24-0x27),
// status byte and CSM key-on. The busy counter is built only when JT12_BUSY_EN is defined.
module jt12_timer_ctrl #(
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       write,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       clr_run_A,
  output logic       clr_run_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic [1:0] ch3_mode,
  output logic       csm_kon,
  output logic       busy
);

  logic [7:0] r_addr;
  logic       r_part;
  logic [1:0] r_load_prev;

  logic w_addr_wr;
  logic w_data_wr;
  logic w_reg_wr;
  logic w_wr_24;
  logic w_wr_25;
  logic w_wr_26;
  logic w_wr_27;

  assign w_addr_wr = write & ~addr[0];
  assign w_data_wr = write &  addr[0];
  // Only part I writes to 0x24..0x27 touch the timer registers.
  assign w_reg_wr  = w_data_wr & ~r_part & (r_addr[7:2] == 6'b001001);
  assign w_wr_24   = w_reg_wr & (r_addr[1:0] == 2'd0);
  assign w_wr_25   = w_reg_wr & (r_addr[1:0] == 2'd1);
  assign w_wr_26   = w_reg_wr & (r_addr[1:0] == 2'd2);
  assign w_wr_27   = w_reg_wr & (r_addr[1:0] == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= 8'h00;
      r_part       <= 1'b0;
      r_load_prev  <= 2'b00;
      value_A      <= 10'd0;
      value_B      <= 8'd0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      clr_run_A    <= 1'b0;
      clr_run_B    <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      ch3_mode     <= 2'b00;
      csm_kon      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle, so a matching write raises them for exactly one clk.
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      clr_run_A  <= 1'b0;
      clr_run_B  <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      // NOTE: non-blocking, so csm_kon uses ch3_mode as it stood before a same-cycle 0x27 write.
      csm_kon    <= overflow_A & (ch3_mode == 2'b10);

      if (w_addr_wr) begin
        r_addr <= din;
        r_part <= addr[1];
      end
      if (w_wr_24) value_A[9:2] <= din;
      if (w_wr_25) value_A[1:0] <= din[1:0];
      if (w_wr_26) value_B      <= din;
      if (w_wr_27) begin
        ch3_mode     <= din[7:6];
        enable_irq_B <= din[3];
        enable_irq_A <= din[2];
        clr_flag_A   <= din[4];
        clr_flag_B   <= din[5];
        // Edge-detect the load bits so rewriting 0x27 never restarts a running timer.
        load_A       <=  din[0] & ~r_load_prev[0];
        load_B       <=  din[1] & ~r_load_prev[1];
        clr_run_A    <= ~din[0] &  r_load_prev[0];
        clr_run_B    <= ~din[1] &  r_load_prev[1];
        r_load_prev  <= din[1:0];
      end
    end
  end

`ifdef JT12_BUSY_EN
  logic [7:0] r_busy_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt <= 8'd0;
    end else if (w_data_wr) begin
      r_busy_cnt <= 8'(BUSY_CYCLES);
    end else if (cen && (r_busy_cnt != 8'd0)) begin
      r_busy_cnt <= r_busy_cnt - 8'd1;
    end
  end

  assign busy = (r_busy_cnt != 8'd0);
`else
  logic w_unused_busy;
  assign w_unused_busy = ^{cen, 8'(BUSY_CYCLES)};
  assign busy = 1'b0;
`endif

  assign dout = {busy, 5'b00000, flag_B, flag_A};

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// tb_jt12_timer_ctrl: scenario tasks plus randomized traffic, checked against a
// register-level reference model of the timer control block.
module tb_jt12_timer_ctrl;

  localparam int BUSY = 32;
`ifdef JT12_BUSY_EN
  localparam bit HAS_BUSY = 1'b1;
`else
  localparam bit HAS_BUSY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       write = 1'b0;
  logic [1:0] addr = 2'b00;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b0;
  logic       overflow_A = 1'b0;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B;
  logic       enable_irq_A, enable_irq_B;
  logic [1:0] ch3_mode;
  logic       csm_kon;
  logic       busy;

  int total = 0;
  int bad   = 0;

  jt12_timer_ctrl #(.BUSY_CYCLES(BUSY)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .write(write), .addr(addr), .din(din),
    .dout(dout), .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .clr_run_A(clr_run_A), .clr_run_B(clr_run_B), .clr_flag_A(clr_flag_A),
    .clr_flag_B(clr_flag_B), .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .ch3_mode(ch3_mode), .csm_kon(csm_kon), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: CPU-visible register file and timer run state.
  logic [9:0] m_value_A;
  logic [7:0] m_value_B;
  logic       m_en_A, m_en_B, m_run_A, m_run_B;
  logic [1:0] m_ch3;
  logic [7:0] m_addr;
  logic       m_part;
  int         m_busy_left;
  logic       m_load_A, m_load_B, m_stop_A, m_stop_B, m_cf_A, m_cf_B, m_csm;

  task automatic model_reset();
    m_value_A = '0; m_value_B = '0; m_en_A = 0; m_en_B = 0; m_run_A = 0; m_run_B = 0;
    m_ch3 = 0; m_addr = 8'h00; m_part = 0; m_busy_left = 0;
    m_load_A = 0; m_load_B = 0; m_stop_A = 0; m_stop_B = 0; m_cf_A = 0; m_cf_B = 0; m_csm = 0;
  endtask

  task automatic model_step(input logic w, input logic [1:0] a, input logic [7:0] d,
                            input logic c, input logic o);
    m_load_A = 0; m_load_B = 0; m_stop_A = 0; m_stop_B = 0; m_cf_A = 0; m_cf_B = 0;
    m_csm = o && (m_ch3 == 2'b10);
    if (w && a[0]) m_busy_left = HAS_BUSY ? BUSY : 0;
    else if (c && m_busy_left > 0) m_busy_left = m_busy_left - 1;
    if (w && !a[0]) begin
      m_addr = d;
      m_part = a[1];
    end else if (w && a[0] && !m_part) begin
      case (m_addr)
        8'h24: m_value_A = {d, m_value_A[1:0]};
        8'h25: m_value_A = {m_value_A[9:2], d[1:0]};
        8'h26: m_value_B = d;
        8'h27: begin
          m_ch3 = d[7:6]; m_en_B = d[3]; m_en_A = d[2];
          m_cf_A = d[4]; m_cf_B = d[5];
          if (d[0] && !m_run_A) m_load_A = 1;
          if (!d[0] && m_run_A) m_stop_A = 1;
          if (d[1] && !m_run_B) m_load_B = 1;
          if (!d[1] && m_run_B) m_stop_B = 1;
          m_run_A = d[0]; m_run_B = d[1];
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [37:0] dut_vec();
    return {dout, value_A, value_B, load_A, load_B, clr_run_A, clr_run_B, clr_flag_A,
            clr_flag_B, enable_irq_A, enable_irq_B, ch3_mode, csm_kon, busy};
  endfunction

  function automatic logic [37:0] exp_vec();
    logic b;
    b = (m_busy_left != 0);
    return {b, 5'b00000, flag_B, flag_A, m_value_A, m_value_B, m_load_A, m_load_B,
            m_stop_A, m_stop_B, m_cf_A, m_cf_B, m_en_A, m_en_B, m_ch3, m_csm, b};
  endfunction

  // One clock: drive at negedge, model the posedge, return at the next negedge.
  task automatic tick(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic c, input logic o);
    write = w; addr = a; din = d; cen = c; overflow_A = o;
    @(posedge clk);
    model_step(w, a, d, c, o);
    @(negedge clk);
    write = 0; cen = 0; overflow_A = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
    end
    total++;
    if (dout !== 8'h00) begin
      bad++; $display("FAIL reset_dout: got %h expected 00", dout);
    end
    total++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_value_a();
    tick(1, 2'b00, 8'h24, 0, 0);
    tick(1, 2'b01, 8'hFA, 0, 0);
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL value_A_hi: got %h expected %h", dut_vec(), exp_vec());
    end
    total++;
    tick(1, 2'b00, 8'h25, 0, 0);
    tick(1, 2'b01, 8'h03, 0, 0);
    if (value_A !== 10'h3EB) begin
      bad++; $display("FAIL value_A: got %h expected 3eb", value_A);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL value_A_state: got %h expected %h", dut_vec(), exp_vec());
    end
    total++;
  endtask

  task automatic test_load_run();
    logic [7:0] seq [4] = '{8'h05, 8'h05, 8'h04, 8'h06};
    tick(1, 2'b00, 8'h27, 0, 0);
    foreach (seq[i]) begin
      tick(1, 2'b01, seq[i], 0, 0);
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL load_run_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      total++;
      tick(0, 2'b00, 8'h00, 0, 0);
      if ({load_A, clr_run_A} !== 2'b00) begin
        bad++; $display("FAIL strobe_width_%0d: got %b expected 00", i, {load_A, clr_run_A});
      end
      total++;
    end
  endtask

  task automatic test_flag_clear();
    tick(1, 2'b00, 8'h27, 0, 0);
    tick(1, 2'b01, 8'h30, 0, 0);
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL flag_clear: got %h expected %h", dut_vec(), exp_vec());
    end
    total++;
    tick(0, 2'b00, 8'h00, 0, 0);
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL flag_clear_end: got %h expected %h", dut_vec(), exp_vec());
    end
    total++;
  endtask

  task automatic test_csm();
    logic [7:0] modes [2] = '{8'h81, 8'h41};
    foreach (modes[i]) begin
      tick(1, 2'b00, 8'h27, 0, 0);
      tick(1, 2'b01, modes[i], 0, 0);
      tick(0, 2'b00, 8'h00, 0, 1);
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL csm_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      total++;
      tick(0, 2'b00, 8'h00, 0, 0);
      if (csm_kon !== 1'b0) begin
        bad++; $display("FAIL csm_width_%0d: got %b expected 0", i, csm_kon);
      end
      total++;
    end
  endtask

  task automatic busy_run(input bit rewrite, output int ticks);
    bit done_rewrite;
    ticks = 0;
    done_rewrite = 0;
    for (int i = 0; i < 300 && m_busy_left > 0; i++) tick(0, 2'b00, 8'h00, 1, 0);
    tick(1, 2'b00, 8'h30, 0, 0);
    tick(1, 2'b01, 8'hAA, 0, 0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (busy !== 1'b1) break;
      if (rewrite && !done_rewrite && ticks == 10) begin
        done_rewrite = 1;
        tick(1, 2'b01, 8'h55, 0, 0);
      end else begin
        if ((cyc % 4) == 3) ticks++;
        tick(0, 2'b00, 8'h00, (cyc % 4) == 3, 0);
      end
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL busy_cycle_%0d: got %h expected %h", cyc, dut_vec(), exp_vec());
      end
      total++;
    end
  endtask

  task automatic test_busy();
    int ticks;
    busy_run(0, ticks);
`ifdef JT12_BUSY_EN
    if (ticks !== BUSY) begin
      bad++; $display("FAIL busy_ticks: got %0d expected %0d", ticks, BUSY);
    end
    total++;
`endif
    busy_run(1, ticks);
`ifdef JT12_BUSY_EN
    if (ticks !== BUSY + 10) begin
      bad++; $display("FAIL busy_extend: got %0d expected %0d", ticks, BUSY + 10);
    end
    total++;
`endif
    tick(1, 2'b01, 8'h00, 0, 0);
    repeat (3) tick(0, 2'b00, 8'h00, 1, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_mid_busy: got %h expected %h", dut_vec(), exp_vec());
    end
    total++;
    @(negedge clk);
    rst_n = 1;
    tick(1, 2'b00, 8'h24, 0, 0);
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick(1, 2'b01, 8'h55, 0, 0);
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_drops_addr: got %h expected %h", dut_vec(), exp_vec());
    end
    total++;
  endtask

  task automatic test_part2();
    logic [7:0] exp_dout;
    tick(1, 2'b00, 8'h26, 0, 0);
    tick(1, 2'b01, 8'h9C, 0, 0);
    tick(1, 2'b10, 8'h27, 0, 0);
    tick(1, 2'b11, 8'hFF, 0, 0);
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL part2_ignored: got %h expected %h", dut_vec(), exp_vec());
    end
    total++;
    flag_A = 1; flag_B = 1;
    #1;
    exp_dout = {HAS_BUSY, 7'b0000011};
    if (dout !== exp_dout) begin
      bad++; $display("FAIL status_byte: got %h expected %h", dout, exp_dout);
    end
    total++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] regs [5] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h2B};
    logic [7:0] d;
    logic [1:0] a;
    for (int i = 0; i < 400; i++) begin
      a = 2'($urandom_range(0, 3));
      if (a[1] && $urandom_range(0, 3) != 0) a[1] = 1'b0;
      d = a[0] ? 8'($urandom) : regs[$urandom_range(0, 4)];
      flag_A = 1'($urandom); flag_B = 1'($urandom);
      tick($urandom_range(0, 2) != 0, a, d, 1'($urandom), 1'($urandom));
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_value_a();
    test_load_run();
    test_flag_clear();
    test_csm();
    test_busy();
    test_part2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt12_timer_ctrl.md
Name: jt12_timer_ctrl

Overview:
CPU-side register front end for the timer pair. It decodes address/data bus writes to registers 0x24–0x27 and produces the timer start values, load/run/flag-clear strobes and IRQ enables. It also generates the status byte (busy, flag_B, flag_A) and the CSM key-on strobe from timer A overflow. It sits between the bus interface and the timer block, and also consumes the timer block's flag and overflow outputs.

Parameters:
BUSY_CYCLES, 32, number of cen ticks busy stays high after a data write (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  chip clock enable; paces the busy counter
write  in  1  one-clk write strobe
addr  in  2  addr[0]: 0=address cycle, 1=data cycle; addr[1]: part select (0=part I)
din  in  8  write data
dout  out  8  status byte {busy,5'b0,flag_B,flag_A}
flag_A  in  1  timer A flag from timer block
flag_B  in  1  timer B flag from timer block
overflow_A  in  1  timer A overflow (one clk_en-qualified cycle)
value_A  out  10  timer A start value NA
value_B  out  8  timer B start value NB
load_A, load_B  out  1  one-clk load strobes
clr_run_A, clr_run_B  out  1  one-clk stop strobes
clr_flag_A, clr_flag_B  out  1  one-clk flag-clear strobes
enable_irq_A, enable_irq_B  out  1  IRQ enable levels
ch3_mode  out  2  reg 0x27 bits 7:6
csm_kon  out  1  one-clk CSM key-on strobe
busy  out  1  write-busy flag

Behaviour:
- Reset (async, rst_n=0): all outputs 0, latched address = 8'h00, part = 0, busy counter = 0, previous load bits = 0.
- Address cycle (write & !addr[0]): latch din as the register address and addr[1] as the part. Writing an address does not start busy.
- Data cycle (write & addr[0]): acted on only when the latched part = 0 and the latched address is 0x24–0x27. Other addresses are ignored by this block but still start busy.
- All register outputs and strobes are registered. A data write in cycle t takes effect in cycle t+1. Every strobe is exactly one clk wide.
- 0x24: value_A[9:2] <= din. 0x25: value_A[1:0] <= din[1:0]. 0x26: value_B <= din. Each write takes effect immediately; there is no double-buffering.
- 0x27:
  - ch3_mode <= din[7:6]; enable_irq_B <= din[3]; enable_irq_A <= din[2].
  - din[4]=1 pulses clr_flag_A; din[5]=1 pulses clr_flag_B. These bits are not stored.
  - Load bits (bit0=A, bit1=B) compared against their previous stored value:
    - 0→1 pulses load_x.
    - 1→0 pulses clr_run_x.
    - 1→1 and 0→0 produce no strobe. Rewriting 0x27 therefore does not restart a running timer.
- csm_kon = overflow_A & (ch3_mode==2'b10), registered (1-clk latency). ch3_mode is the value held before any same-cycle 0x27 write.
- Busy:
  - A data write loads the counter with BUSY_CYCLES; busy = (counter != 0).
  - The counter decrements on cen only.
  - A write while busy is still accepted and reloads the counter to BUSY_CYCLES.
- dout is combinational from busy, flag_B and flag_A. It is valid every cycle, independent of read strobes.
- Reset mid-busy clears busy immediately. Reset between an address cycle and a data cycle discards the latched address.

Optional Feature:
JT12_BUSY_EN.
- Defined: busy counter as above.
- Undefined: no counter is synthesised; busy and dout[7] are tied to 0, and BUSY_CYCLES is unused.

Test Plan:
- Reset release, then write {addr=0,din=8'h24}, {addr=1,din=8'hFA}, {addr=0,8'h25}, {addr=1,8'h03} -> value_A=10'h3EB. No strobes fire. busy goes high after each data write.
- Write 0x27=8'h05 -> load_A pulses 1 clk, enable_irq_A=1. A second write 0x27=8'h05 -> no load_A. Then 0x27=8'h04 -> clr_run_A pulses once.
- Write 0x27=8'h30 -> clr_flag_A and clr_flag_B pulse together for 1 clk. ch3_mode=0. Enables clear.
- Write 0x27=8'h81, then pulse overflow_A -> csm_kon pulses 1 clk later. With ch3_mode=2'b01, overflow_A -> no csm_kon.
- cen every 4 clk, BUSY_CYCLES=32, data write -> busy high for exactly 32 cen ticks. A second write at tick 10 extends busy to tick 42. Assert rst_n=0 mid-busy -> busy=0 at once.
- Part II write {addr=2'b10,8'h27}, then {addr=2'b11,8'hFF} -> no timer outputs change, busy asserts. Driving flag_A=1, flag_B=1 -> dout=8'h83 while busy.
